// File: rtl/pipelined_dmem_responder.sv
// MEM-stage data-memory responder: word array with LATENCY-cycle access, stall and load extension.
// Optional misaligned-access trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
module pipelined_dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_CTL_mem_read,
    input  logic        i_CTL_mem_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata,
    output logic        o_done,
    output logic        o_stall,
    output logic        o_misaligned
);
    localparam int AW = ADDR_WIDTH + 2;
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic            wr_q, wr_d;

    logic [31:0]     mem_q [2**ADDR_WIDTH];

    logic            req, done, stall;
    logic [AW-1:0]   acc_addr, eff_addr;
    logic [31:0]     acc_wdata;
    logic [2:0]      acc_f3;
    logic            acc_wr;
    logic            is_byte, is_half, is_word, is_signed, mis;
    logic [1:0]      lane;
    logic [31:0]     rword, byte_sh, half_sh, ld_ext, wmask, wpat, mem_wdata;
    logic            mem_we;
    logic            unused_addr_hi;

    assign req            = i_CTL_mem_read | i_CTL_mem_write;
    assign unused_addr_hi = ^i_addr[31:AW];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        wr_d      = wr_q;
        done      = 1'b0;
        stall     = 1'b0;
        acc_addr  = i_addr[AW-1:0];
        acc_wdata = i_wdata;
        acc_f3    = i_funct3;
        acc_wr    = i_CTL_mem_write;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        done = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        addr_d  = i_addr[AW-1:0];
                        wdata_d = i_wdata;
                        f3_d    = i_funct3;
                        wr_d    = i_CTL_mem_write;
                        cnt_d   = CW'(LATENCY - 2);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Captured request drives the access; live inputs are ignored here.
                acc_addr  = addr_q;
                acc_wdata = wdata_q;
                acc_f3    = f3_q;
                acc_wr    = wr_q;
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        is_byte   = (acc_f3 == 3'b000) || (acc_f3 == 3'b100);
        is_half   = (acc_f3 == 3'b001) || (acc_f3 == 3'b101);
        is_word   = !is_byte && !is_half;
        is_signed = !acc_f3[2];
        eff_addr  = acc_addr;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (is_half && acc_addr[0]) || (is_word && (acc_addr[1:0] != 2'b00));
`else
        mis = 1'b0;
        if (is_half) eff_addr[0]   = 1'b0;
        if (is_word) eff_addr[1:0] = 2'b00;
`endif
        lane    = eff_addr[1:0];
        rword   = mem_q[eff_addr[AW-1:2]];
        byte_sh = rword >> {lane, 3'b000};
        half_sh = rword >> {lane[1], 4'b0000};
        if (is_byte)
            ld_ext = {{24{is_signed & byte_sh[7]}}, byte_sh[7:0]};
        else if (is_half)
            ld_ext = {{16{is_signed & half_sh[15]}}, half_sh[15:0]};
        else
            ld_ext = rword;
        wmask = is_byte ? (32'h0000_00FF << {lane, 3'b000}) :
                is_half ? (32'h0000_FFFF << {lane[1], 4'b0000}) : '1;
        wpat  = is_byte ? {4{acc_wdata[7:0]}} :
                is_half ? {2{acc_wdata[15:0]}} : acc_wdata;
        mem_wdata = (rword & ~wmask) | (wpat & wmask);
    end

    // Outputs are gated by reset so an abort is visible without waiting for a clock.
    assign mem_we       = i_reset_n && done && acc_wr && !mis;
    assign o_done       = i_reset_n && done;
    assign o_stall      = i_reset_n && stall;
    assign o_misaligned = i_reset_n && done && mis;
    assign o_rdata      = (i_reset_n && done && !acc_wr && !mis) ? ld_ext : '0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[eff_addr[AW-1:2]] <= mem_wdata;
    end
endmodule

// File: tb/tb_pipelined_dmem_responder.sv
// Scoreboard bench: one LATENCY=1 and one LATENCY=3 responder against a byte-array reference model.
module tb_pipelined_dmem_responder;
    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic [7:0]  stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        rd [2];
    logic        wr [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [2:0]  f3 [2];
    logic [31:0] rdata [2];
    logic        done [2];
    logic        stall [2];
    logic        mis [2];

    int checks = 0;
    int failures = 0;
    int srun [2];
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] mb [2][4096];

    always #5 clk = ~clk;

    pipelined_dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_lat1 (
        .i_clk(clk), .i_reset_n(rst_n[0]), .i_CTL_mem_read(rd[0]), .i_CTL_mem_write(wr[0]),
        .i_addr(addr[0]), .i_wdata(wdata[0]), .i_funct3(f3[0]),
        .o_rdata(rdata[0]), .o_done(done[0]), .o_stall(stall[0]), .o_misaligned(mis[0]));

    pipelined_dmem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_lat3 (
        .i_clk(clk), .i_reset_n(rst_n[1]), .i_CTL_mem_read(rd[1]), .i_CTL_mem_write(wr[1]),
        .i_addr(addr[1]), .i_wdata(wdata[1]), .i_funct3(f3[1]),
        .o_rdata(rdata[1]), .o_done(done[1]), .o_stall(stall[1]), .o_misaligned(mis[1]));

    // Byte-addressed model: memory is 4 KiB, upper address bits alias.
    function automatic void model(input int d, input bit w, input logic [31:0] a_in,
                                  input logic [31:0] wd, input logic [2:0] f,
                                  output logic [31:0] rv, output bit m);
        int size;
        int a;
        logic [31:0] v;
        size = (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
        a = int'(a_in[11:0]);
        rv = 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
        m = (a % size) != 0;
`else
        m = 1'b0;
        a = a - (a % size);
`endif
        if (m) return;
        if (w) begin
            for (int i = 0; i < size; i++) mb[d][a + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(mb[d][a + i]) << (8 * i));
            if (f == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (f == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            rv = v;
        end
    endfunction

    task automatic issue(input int d, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f);
        exp_t e;
        logic [31:0] x;
        bit m;
        int lat;
        lat = (d == 0) ? 1 : 3;
        model(d, w, a, wd, f, x, m);
        e.rdata = x;
        e.mis = m;
        e.stalls = 8'(lat - 1);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; f3[d] = f;
        @(posedge clk); #1;
        for (int k = 0; k < lat - 1; k++) begin
            rd[d] = 1'($urandom); wr[d] = 1'($urandom);
            addr[d] = $urandom; wdata[d] = $urandom; f3[d] = 3'($urandom);
            @(posedge clk); #1;
        end
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    task automatic mon(input int d);
        exp_t e;
        int qs;
        if (!rst_n[d]) begin
            srun[d] = 0;
            return;
        end
        qs = (d == 0) ? q0.size() : q1.size();
        if (done[d]) begin
            checks++;
            if (qs == 0) begin
                failures++;
                $display("FAIL unexpected_done dut%0d rdata=%h", d, rdata[d]);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                if (rdata[d] !== e.rdata || mis[d] !== e.mis || srun[d] != int'(e.stalls) || stall[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL resp dut%0d got rdata=%h mis=%b stalls=%0d stall=%b exp rdata=%h mis=%b stalls=%0d stall=0",
                             d, rdata[d], mis[d], srun[d], stall[d], e.rdata, e.mis, e.stalls);
                end
            end
            srun[d] = 0;
        end else if (stall[d]) begin
            srun[d]++;
            if (srun[d] > 8) begin
                checks++;
                failures++;
                $display("FAIL stall_bound dut%0d got %0d stall cycles exp <=8", d, srun[d]);
                srun[d] = 0;
            end
        end else begin
            checks++;
            if (rdata[d] !== 32'h0 || mis[d] !== 1'b0) begin
                failures++;
                $display("FAIL idle_out dut%0d got rdata=%h mis=%b exp 0/0", d, rdata[d], mis[d]);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic check_zero_out(input int d, input string name);
        checks++;
        if (rdata[d] !== 32'h0 || done[d] !== 1'b0 || stall[d] !== 1'b0 || mis[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s dut%0d got rdata=%h done=%b stall=%b mis=%b exp all 0",
                     name, d, rdata[d], done[d], stall[d], mis[d]);
        end
    endtask

    task automatic random_ops(input int d, input int n);
        int kind;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            kind = int'($urandom_range(0, 4));
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            case (kind)
                0, 1: issue(d, 1'b1, 1'b0, a, $urandom, 3'($urandom));
                2:    issue(d, 1'b0, 1'b1, a, $urandom, 3'($urandom));
                3:    issue(d, 1'b1, 1'b1, a, $urandom, 3'($urandom));
                default: begin @(posedge clk); #1; end
            endcase
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; rd[d] = 1'b1; wr[d] = 1'b1;
            addr[d] = 32'h10; wdata[d] = 32'h5555_5555; f3[d] = 3'b010; srun[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_zero_out(0, "reset_out");
        check_zero_out(1, "reset_out");
        for (int d = 0; d < 2; d++) begin rd[d] = 1'b0; wr[d] = 1'b0; end
        @(posedge clk); #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++) issue(d, 1'b0, 1'b1, 32'(w * 4), $urandom, 3'b010);

        // LATENCY=1 directed sequence
        issue(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        issue(0, 1'b0, 1'b1, 32'h13, 32'h0000_0080, 3'b000);
        issue(0, 1'b1, 1'b0, 32'h13, 32'h0, 3'b000);
        issue(0, 1'b1, 1'b0, 32'h13, 32'h0, 3'b100);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        issue(0, 1'b1, 1'b0, 32'h12, 32'h0, 3'b001);
        issue(0, 1'b1, 1'b0, 32'h12, 32'h0, 3'b101);
        issue(0, 1'b1, 1'b1, 32'h30, 32'hA5A5_A5A5, 3'b010);
        issue(0, 1'b1, 1'b0, 32'h30, 32'h0, 3'b010);
        issue(0, 1'b1, 1'b0, 32'h11, 32'h0, 3'b001);
        issue(0, 1'b0, 1'b1, 32'h11, 32'hFFFF_FFFF, 3'b001);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        issue(0, 1'b1, 1'b0, 32'h0000_1010, 32'h0, 3'b011);

        // LATENCY=3: back-to-back loads, then a store aborted by reset
        issue(1, 1'b0, 1'b1, 32'h20, 32'h1111_1111, 3'b010);
        issue(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
        issue(1, 1'b1, 1'b0, 32'h24, 32'h0, 3'b010);
        rd[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h1234_5678; f3[1] = 3'b010;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        #1;
        check_zero_out(1, "abort_out");
        wr[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        issue(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
        issue(1, 1'b1, 1'b0, 32'h11, 32'h0, 3'b001);

        random_ops(0, 150);
        random_ops(1, 150);

        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d/%0d exp 0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
